div_sched: RTL and testbench

Iterative divide/modulo scheduler for the EX stage. Accepts one `div`/`mod`/`divu`/`modu` request at a time from EX and holds EX stalled through a valid/ready handshake. Sequences a radix-2 restoring divider over XLEN cycles, applies sign correction, and returns the result with its destination tag to the EX→MEM path. A flush from branch redirect cancels any in-flight operation.

---
 rtl/div_pkg.sv | 27 ++
 rtl/div_step.sv | 21 ++
 rtl/div_sched.sv | 183 ++++++++++++++++++
 tb/tb_div_sched.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared encodings for the iterative divide scheduler.
// Optional feature macro: DIV_ZERO_BYPASS_EN.
package div_pkg;

  localparam int DIV_XLEN  = 32;
  localparam int DIV_CNT_W = $clog2(DIV_XLEN);

  localparam logic [1:0] DIV_OP_DIV  = 2'b00;
  localparam logic [1:0] DIV_OP_MOD  = 2'b01;
  localparam logic [1:0] DIV_OP_DIVU = 2'b10;
  localparam logic [1:0] DIV_OP_MODU = 2'b11;

  typedef enum logic [1:0] {
    DIV_ST_IDLE = 2'b00,
    DIV_ST_RUN  = 2'b01,
    DIV_ST_DONE = 2'b10
  } div_st_e;

  function automatic logic div_op_signed(input logic [1:0] op);
    return ~op[1];
  endfunction

  function automatic logic div_op_is_mod(input logic [1:0] op);
    return op[0];
  endfunction

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring division iteration, purely combinational.
// Optional feature macro: DIV_ZERO_BYPASS_EN (not used here).
module div_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN:0]   rem_i,
  input  logic            dvd_bit_i,
  input  logic [XLEN-1:0] dvs_i,
  output logic [XLEN:0]   rem_o,
  output logic            q_o
);

  logic [XLEN:0] shf;
  logic [XLEN:0] diff;

  assign shf   = {rem_i[XLEN-1:0], dvd_bit_i};
  assign diff  = shf - {1'b0, dvs_i};
  assign q_o   = ~diff[XLEN];
  assign rem_o = q_o ? diff : shf;

endmodule

// File: rtl/div_sched.sv
// EX-stage div/mod scheduler: FSM, counter, operand/tag regs, sign fix.
// Optional feature macro: DIV_ZERO_BYPASS_EN (zero divisor skips RUN).
module div_sched
  import div_pkg::*;
#(
  parameter int XLEN = DIV_XLEN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [1:0]      req_op,
  input  logic [XLEN-1:0] req_src1,
  input  logic [XLEN-1:0] req_src2,
  input  logic [4:0]      req_dest,
  input  logic [31:0]     req_pc,
  input  logic            flush,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_data,
  output logic [4:0]      resp_dest,
  output logic [31:0]     resp_pc,
  output logic            busy
);

  localparam int CW = $clog2(XLEN);

  div_st_e         state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [1:0]      op_q, op_d;
  logic [4:0]      dest_q, dest_d;
  logic [31:0]     pc_q, pc_d;
  logic [XLEN-1:0] dvd_q, dvd_d;
  logic [XLEN-1:0] dvs_q, dvs_d;
  logic [XLEN:0]   rem_q, rem_d;
  logic            q_neg_q, q_neg_d;
  logic            r_neg_q, r_neg_d;
  logic [XLEN-1:0] data_q, data_d;
  logic            valid_q, valid_d;
  logic            busy_q, busy_d;

  logic [XLEN:0]   rem_nx;
  logic            q_bit;
  logic [XLEN-1:0] q_fin;
  logic [XLEN-1:0] r_fin;
  logic [XLEN-1:0] res;
  logic            sgn;
  logic            s1_neg;
  logic            s2_neg;

  div_step #(.XLEN(XLEN)) u_step (
    .rem_i     (rem_q),
    .dvd_bit_i (dvd_q[XLEN-1]),
    .dvs_i     (dvs_q),
    .rem_o     (rem_nx),
    .q_o       (q_bit)
  );

  // Dividend register shifts left; quotient bits fill in from the LSB.
  assign q_fin = {dvd_q[XLEN-2:0], q_bit};
  assign r_fin = rem_nx[XLEN-1:0];

  always_comb begin
    res = q_neg_q ? -q_fin : q_fin;
    if (div_op_is_mod(op_q)) begin
      res = r_neg_q ? -r_fin : r_fin;
    end
  end

  assign sgn    = div_op_signed(req_op);
  assign s1_neg = sgn & req_src1[XLEN-1];
  assign s2_neg = sgn & req_src2[XLEN-1];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    dest_d  = dest_q;
    pc_d    = pc_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    rem_d   = rem_q;
    q_neg_d = q_neg_q;
    r_neg_d = r_neg_q;
    data_d  = data_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    if (flush) begin
      state_d = DIV_ST_IDLE;
      cnt_d   = '0;
      valid_d = 1'b0;
      busy_d  = 1'b0;
    end else begin
      unique case (1'b1)
        (state_q == DIV_ST_IDLE): begin
          if (req_valid) begin
            op_d    = req_op;
            dest_d  = req_dest;
            pc_d    = req_pc;
            dvd_d   = s1_neg ? -req_src1 : req_src1;
            dvs_d   = s2_neg ? -req_src2 : req_src2;
            q_neg_d = s1_neg ^ s2_neg;
            r_neg_d = s1_neg;
            rem_d   = '0;
            cnt_d   = '0;
            state_d = DIV_ST_RUN;
            busy_d  = 1'b1;
`ifdef DIV_ZERO_BYPASS_EN
            if (req_src2 == '0) begin
              state_d = DIV_ST_DONE;
              valid_d = 1'b1;
              data_d  = div_op_is_mod(req_op) ? req_src1 : '1;
            end
`endif
          end
        end
        (state_q == DIV_ST_RUN): begin
          dvd_d = q_fin;
          rem_d = rem_nx;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CW'(XLEN - 1)) begin
            cnt_d   = '0;
            state_d = DIV_ST_DONE;
            valid_d = 1'b1;
            data_d  = res;
          end
        end
        (state_q == DIV_ST_DONE): begin
          if (resp_ready) begin
            state_d = DIV_ST_IDLE;
            valid_d = 1'b0;
            busy_d  = 1'b0;
          end
        end
        default: begin
          state_d = DIV_ST_IDLE;
          valid_d = 1'b0;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= DIV_ST_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      dest_q  <= '0;
      pc_q    <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      dest_q  <= dest_d;
      pc_q    <= pc_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      rem_q   <= rem_d;
      q_neg_q <= q_neg_d;
      r_neg_q <= r_neg_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
    end
  end

  assign req_ready  = (state_q == DIV_ST_IDLE);
  assign resp_valid = valid_q;
  assign resp_data  = data_q;
  assign resp_dest  = dest_q;
  assign resp_pc    = pc_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_div_sched.sv
// Self-checking bench for div_sched: vector table plus corner sequences.
// Honors DIV_ZERO_BYPASS_EN for zero-divisor latency and results.
module tb_div_sched;
  import div_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [31:0] req_src1;
  logic [31:0] req_src2;
  logic [4:0]  req_dest;
  logic [31:0] req_pc;
  logic        flush;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_data;
  logic [4:0]  resp_dest;
  logic [31:0] resp_pc;
  logic        busy;

  always #5 clk = ~clk;

  div_sched #(.XLEN(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_src1   (req_src1),
    .req_src2   (req_src2),
    .req_dest   (req_dest),
    .req_pc     (req_pc),
    .flush      (flush),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_dest  (resp_dest),
    .resp_pc    (resp_pc),
    .busy       (busy)
  );

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  dest;
    logic [31:0] pc;
    int          lat;
  } exp_t;

  localparam int NV = 16;
  vec_t v [NV];
  exp_t sb [$];
  int nchk = 0;
  int nerr = 0;

`ifdef DIV_ZERO_BYPASS_EN
  localparam int ZLAT = 1;
  localparam logic [31:0] SDIV0_NEG = 32'hFFFF_FFFF;
`else
  localparam int ZLAT = 33;
  localparam logic [31:0] SDIV0_NEG = 32'h0000_0001;
`endif

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Drive one request at a negedge; returns at the negedge after accept.
  task automatic send(input logic [1:0] op, input logic [31:0] a,
                      input logic [31:0] b, input logic [4:0] dest,
                      input logic [31:0] pc, input logic [31:0] exp);
    exp_t e;
    @(negedge clk);
    chk("req_ready_idle", {63'd0, req_ready}, 64'd1);
    req_valid = 1'b1;
    req_op    = op;
    req_src1  = a;
    req_src2  = b;
    req_dest  = dest;
    req_pc    = pc;
    e.data = exp;
    e.dest = dest;
    e.pc   = pc;
    e.lat  = (b == 32'd0) ? ZLAT : 33;
    sb.push_back(e);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  // Wait for the response, compare against the scoreboard, then handshake.
  task automatic recv(input string name, input int nhold);
    int k = 0;
    exp_t e;
    while (!resp_valid && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (!resp_valid || sb.size() == 0) begin
      nchk++;
      nerr++;
      $display("FAIL %s timeout: resp_valid %0b after %0d cycles", name,
               resp_valid, k);
      sb.delete();
      return;
    end
    e = sb.pop_front();
    chk({name, "_lat"}, 64'(k + 1), 64'(e.lat));
    chk({name, "_data"}, {32'd0, resp_data}, {32'd0, e.data});
    chk({name, "_dest"}, {59'd0, resp_dest}, {59'd0, e.dest});
    chk({name, "_pc"}, {32'd0, resp_pc}, {32'd0, e.pc});
    for (int i = 0; i < nhold; i++) begin
      @(negedge clk);
      chk("hold_valid", {63'd0, resp_valid}, 64'd1);
      chk("hold_ready", {63'd0, req_ready}, 64'd0);
      chk("hold_data", {32'd0, resp_data}, {32'd0, e.data});
      chk("hold_tag", {27'd0, resp_dest, resp_pc}, {27'd0, e.dest, e.pc});
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    chk({name, "_post_ready"}, {63'd0, req_ready}, 64'd1);
    chk({name, "_post_valid"}, {63'd0, resp_valid}, 64'd0);
  endtask

  initial begin
    bit seen;

    v[0]  = '{DIV_OP_DIV,  32'd7,         32'd2,         32'd3};
    v[1]  = '{DIV_OP_MOD,  32'd7,         32'd2,         32'd1};
    v[2]  = '{DIV_OP_MOD,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF};
    v[3]  = '{DIV_OP_DIV,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD};
    v[4]  = '{DIV_OP_DIVU, 32'hFFFF_FFFF, 32'h10,        32'h0FFF_FFFF};
    v[5]  = '{DIV_OP_MODU, 32'hFFFF_FFFF, 32'h10,        32'hF};
    v[6]  = '{DIV_OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000};
    v[7]  = '{DIV_OP_MOD,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0};
    v[8]  = '{DIV_OP_DIVU, 32'd5,         32'd0,         32'hFFFF_FFFF};
    v[9]  = '{DIV_OP_MODU, 32'd5,         32'd0,         32'd5};
    v[10] = '{DIV_OP_DIV,  32'hFFFF_FFF9, 32'd0,         SDIV0_NEG};
    v[11] = '{DIV_OP_MOD,  32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9};
    v[12] = '{DIV_OP_DIV,  32'd100,       32'hFFFF_FFF9, 32'hFFFF_FFF2};
    v[13] = '{DIV_OP_MOD,  32'd100,       32'hFFFF_FFF9, 32'd2};
    v[14] = '{DIV_OP_DIVU, 32'h8000_0000, 32'd3,         32'h2AAA_AAAA};
    v[15] = '{DIV_OP_DIV,  32'd9,         32'd0,         32'hFFFF_FFFF};

    rst = 1'b1;
    req_valid = 1'b0;
    req_op = 2'b00;
    req_src1 = '0;
    req_src2 = '0;
    req_dest = '0;
    req_pc = '0;
    flush = 1'b0;
    resp_ready = 1'b0;

    @(negedge clk);
    chk("rst_ready", {63'd0, req_ready}, 64'd1);
    chk("rst_valid", {63'd0, resp_valid}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_data", {32'd0, resp_data}, 64'd0);
    chk("rst_tag", {27'd0, resp_dest, resp_pc}, 64'd0);
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      send(v[i].op, v[i].a, v[i].b, 5'(i + 1), 32'h1000 + 32'(i * 4),
           v[i].exp);
      recv($sformatf("vec%0d", i), 0);
    end

    // Backpressure: result must hold for 5 cycles with ready low.
    send(DIV_OP_DIV, 32'd100, 32'd7, 5'd20, 32'hCAFE_0000, 32'd14);
    recv("hold", 5);

    // Flush in the middle of RUN kills the request silently.
    send(DIV_OP_DIVU, 32'd1000, 32'd10, 5'd3, 32'h2000, 32'd100);
    repeat (10) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_ready", {63'd0, req_ready}, 64'd1);
    chk("flush_busy", {63'd0, busy}, 64'd0);
    void'(sb.pop_back());
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (resp_valid) seen = 1'b1;
    end
    chk("flush_no_resp", {63'd0, seen}, 64'd0);
    send(DIV_OP_DIV, 32'd9, 32'd3, 5'd4, 32'h2004, 32'd3);
    recv("after_flush", 0);

    // Flush wins over a simultaneous request.
    @(negedge clk);
    req_valid = 1'b1;
    req_op = DIV_OP_DIV;
    req_src1 = 32'd8;
    req_src2 = 32'd2;
    flush = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    flush = 1'b0;
    chk("flush_req_busy", {63'd0, busy}, 64'd0);
    chk("flush_req_ready", {63'd0, req_ready}, 64'd1);

    // Asynchronous reset mid-RUN clears everything immediately.
    send(DIV_OP_DIV, 32'd50, 32'd5, 5'd9, 32'h3000, 32'd10);
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_ready", {63'd0, req_ready}, 64'd1);
    chk("arst_busy", {63'd0, busy}, 64'd0);
    chk("arst_valid", {63'd0, resp_valid}, 64'd0);
    chk("arst_data", {32'd0, resp_data}, 64'd0);
    chk("arst_tag", {27'd0, resp_dest, resp_pc}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    void'(sb.pop_back());

    send(DIV_OP_MODU, 32'd50, 32'd7, 5'd11, 32'h3004, 32'd1);
    recv("after_rst", 0);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
